// File: rtl/write_back_pkg.sv
// write_back_pkg: shared encodings and widths for the write-back stage
package write_back_pkg;

    typedef enum logic [1:0] {
        MEM_ALU  = 2'd0,
        MEM_LOAD = 2'd1,
        MEM_PC1  = 2'd2,
        MEM_REG  = 2'd3
    } memtoreg_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_COND = 2'd1,
        BR_JUMP = 2'd2,
        BR_JREG = 2'd3
    } branch_e;

    localparam int WB_XLEN     = 32;
    localparam int WB_REG_AW   = 5;
    localparam int WB_JUMP_W   = 26;
    localparam int UART_BYTE_W = 8;

endpackage

// File: rtl/wb_rx_fifo.sv
// wb_rx_fifo: synchronous FIFO for received UART bytes with a sticky overflow flag
module wb_rx_fifo #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic          overflow
);

    logic [AW:0]   wr_ptr, rd_ptr;
    logic [DW-1:0] mem [2**AW];
    logic          do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer and overflow state; a push into a full FIFO without a pop is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (push & ~do_push) overflow <= 1'b1;
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/write_back.sv
// write_back: final pipeline stage - value select, register-file write port,
// branch resolution and UART rx FIFO. Optional macro WRITE_BACK_RX_BYPASS_EN lets
// a byte arriving at an empty FIFO feed a waiting UART read in the same cycle.
module write_back
    import write_back_pkg::*;
#(
    parameter int INST_MEM_WIDTH = 5,
    parameter int RX_FIFO_AW     = 4
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      distinct,
    input  logic                      AorF,
    input  logic                      RegWrite,
    input  logic [1:0]                MemtoReg,
    input  logic [1:0]                Branch,
    input  logic                      UARTtoReg,
    input  logic [WB_XLEN-1:0]        read_data,
    input  logic [WB_XLEN-1:0]        register_data,
    input  logic [WB_XLEN-1:0]        alu_result,
    input  logic [WB_REG_AW-1:0]      rdist,
    input  logic [WB_JUMP_W-1:0]      inst_index,
    input  logic [INST_MEM_WIDTH-1:0] pc,
    input  logic [INST_MEM_WIDTH-1:0] pc1,
    input  logic [INST_MEM_WIDTH-1:0] pc2,
    input  logic                      uart_rx_valid,
    input  logic [UART_BYTE_W-1:0]    uart_rx_data,
    output logic                      stall,
    output logic                      gpr_we,
    output logic                      fpr_we,
    output logic [WB_REG_AW-1:0]      wb_addr,
    output logic [WB_XLEN-1:0]        wb_data,
    output logic                      branch_taken,
    output logic [INST_MEM_WIDTH-1:0] branch_target,
    output logic                      rx_overflow
);

    logic                      fifo_empty, fifo_full;
    logic [UART_BYTE_W-1:0]    fifo_dout, rx_byte;
    logic                      bypass, accept, pop, push;
    logic [WB_XLEN-1:0]        wb_value;
    logic                      taken;
    logic [INST_MEM_WIDTH-1:0] target;
    memtoreg_e                 mem_sel;
    branch_e                   br_sel;
    logic                      unused;

    assign unused  = ^{pc, inst_index[WB_JUMP_W-1:INST_MEM_WIDTH], fifo_full};
    assign mem_sel = memtoreg_e'(MemtoReg);
    assign br_sel  = branch_e'(Branch);

`ifdef WRITE_BACK_RX_BYPASS_EN
    assign bypass = distinct & UARTtoReg & fifo_empty & uart_rx_valid;
`else
    assign bypass = 1'b0;
`endif

    // Stall is gated by reset so it drops the moment reset is asserted.
    assign stall   = reset & distinct & UARTtoReg & fifo_empty & ~bypass;
    assign accept  = distinct & ~stall;
    assign pop     = accept & UARTtoReg & ~bypass;
    assign push    = uart_rx_valid & ~bypass;
    assign rx_byte = bypass ? uart_rx_data : fifo_dout;

    wb_rx_fifo #(
        .AW(RX_FIFO_AW),
        .DW(UART_BYTE_W)
    ) u_rx_fifo (
        .clk     (CLK),
        .rst_n   (reset),
        .push    (push),
        .pop     (pop),
        .din     (uart_rx_data),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .overflow(rx_overflow)
    );

    // Write-back value: UART byte overrides the MemtoReg selection.
    always_comb begin
        wb_value = alu_result;
        case (mem_sel)
            MEM_ALU:  wb_value = alu_result;
            MEM_LOAD: wb_value = read_data;
            MEM_PC1:  wb_value = {{(WB_XLEN-INST_MEM_WIDTH){1'b0}}, pc1};
            MEM_REG:  wb_value = register_data;
        endcase
        if (UARTtoReg) wb_value = {{(WB_XLEN-UART_BYTE_W){1'b0}}, rx_byte};
    end

    // Branch resolution; an untaken conditional branch reports target 0.
    always_comb begin
        taken  = 1'b0;
        target = '0;
        case (br_sel)
            BR_NONE: ;
            BR_COND: begin
                taken  = alu_result[0];
                target = alu_result[0] ? pc2 : '0;
            end
            BR_JUMP: begin
                taken  = 1'b1;
                target = inst_index[INST_MEM_WIDTH-1:0];
            end
            BR_JREG: begin
                taken  = 1'b1;
                target = register_data[INST_MEM_WIDTH-1:0];
            end
        endcase
    end

    // Output registers: valid for exactly one cycle after an accepted instruction.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            gpr_we        <= 1'b0;
            fpr_we        <= 1'b0;
            wb_addr       <= '0;
            wb_data       <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else begin
            gpr_we        <= accept & RegWrite & ~AorF & (|rdist);
            fpr_we        <= accept & RegWrite & AorF;
            wb_addr       <= accept ? rdist : '0;
            wb_data       <= accept ? wb_value : '0;
            branch_taken  <= accept & taken;
            branch_target <= accept ? target : '0;
        end
    end

endmodule

// File: tb/tb_write_back.sv
// tb_write_back: directed bench for write_back with a queue-based reference model
module tb_write_back;

`ifdef WRITE_BACK_RX_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        distinct, AorF, RegWrite, UARTtoReg, uart_rx_valid;
    logic [1:0]  MemtoReg, Branch;
    logic [31:0] read_data, register_data, alu_result;
    logic [4:0]  rdist, pc, pc1, pc2;
    logic [25:0] inst_index;
    logic [7:0]  uart_rx_data;
    logic        stall, gpr_we, fpr_we, branch_taken, rx_overflow;
    logic [4:0]  wb_addr, branch_target;
    logic [31:0] wb_data;

    int total = 0;
    int bad = 0;

    write_back #(.INST_MEM_WIDTH(5), .RX_FIFO_AW(4)) dut (
        .CLK(CLK), .reset(reset), .distinct(distinct), .AorF(AorF), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .Branch(Branch), .UARTtoReg(UARTtoReg), .read_data(read_data),
        .register_data(register_data), .alu_result(alu_result), .rdist(rdist),
        .inst_index(inst_index), .pc(pc), .pc1(pc1), .pc2(pc2), .uart_rx_valid(uart_rx_valid),
        .uart_rx_data(uart_rx_data), .stall(stall), .gpr_we(gpr_we), .fpr_we(fpr_we),
        .wb_addr(wb_addr), .wb_data(wb_data), .branch_taken(branch_taken),
        .branch_target(branch_target), .rx_overflow(rx_overflow)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    logic [7:0]  mq[$];
    logic        e_gpr, e_fpr, e_bt, e_ovf;
    logic [4:0]  e_addr, e_tgt;
    logic [31:0] e_data;
    logic        m_byp, m_acc, m_pop, m_tk;
    logic [7:0]  m_byte;
    logic [31:0] m_val;

    function automatic bit m_stall();
        return reset && distinct && UARTtoReg && (mq.size() == 0) && !(BYP && uart_rx_valid);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: evaluates each clock edge from the instruction-level rules.
    initial forever begin
        @(posedge CLK or negedge reset);
        if (!reset) begin
            mq.delete();
            {e_gpr, e_fpr, e_bt, e_ovf} = '0;
            e_addr = '0; e_tgt = '0; e_data = '0;
        end else begin
            m_byp = BYP && distinct && UARTtoReg && (mq.size() == 0) && uart_rx_valid;
            m_acc = distinct && !m_stall();
            m_pop = m_acc && UARTtoReg && !m_byp;
            m_byte = m_byp ? uart_rx_data : (m_pop ? mq[0] : 8'h00);
            if (m_pop) void'(mq.pop_front());
            if (uart_rx_valid && !m_byp) begin
                if (mq.size() < DEPTH) mq.push_back(uart_rx_data);
                else e_ovf = 1'b1;
            end
            if (UARTtoReg) m_val = {24'h0, m_byte};
            else if (MemtoReg == 2'd0) m_val = alu_result;
            else if (MemtoReg == 2'd1) m_val = read_data;
            else if (MemtoReg == 2'd2) m_val = {27'h0, pc1};
            else m_val = register_data;
            m_tk = (Branch == 2'd1) ? alu_result[0] : (Branch != 2'd0);
            e_gpr  = m_acc && RegWrite && !AorF && (rdist != 0);
            e_fpr  = m_acc && RegWrite && AorF;
            e_addr = m_acc ? rdist : 5'd0;
            e_data = m_acc ? m_val : 32'd0;
            e_bt   = m_acc && m_tk;
            e_tgt  = !(m_acc && m_tk) ? 5'd0 :
                     (Branch == 2'd1) ? pc2 :
                     (Branch == 2'd2) ? inst_index[4:0] : register_data[4:0];
        end
    end

    // Compare process: every negedge, all outputs against the model.
    initial forever begin
        @(negedge CLK);
        chk("stall", stall, m_stall());
        chk("gpr_we", gpr_we, e_gpr);
        chk("fpr_we", fpr_we, e_fpr);
        chk("wb_addr", wb_addr, e_addr);
        chk("wb_data", wb_data, e_data);
        chk("branch_taken", branch_taken, e_bt);
        chk("branch_target", branch_target, e_tgt);
        chk("rx_overflow", rx_overflow, e_ovf);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic clr();
        distinct = 0; AorF = 0; RegWrite = 0; MemtoReg = 0; Branch = 0; UARTtoReg = 0;
        read_data = 0; register_data = 0; alu_result = 0; rdist = 0; inst_index = 0;
        pc = 0; pc1 = 0; pc2 = 0; uart_rx_valid = 0; uart_rx_data = 0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue();
        step();
        clr();
        @(negedge CLK);
    endtask

    bit done;

    initial begin
        clr();
        step(); step();
        reset = 1'b1;
        // 1: bubbles only
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("idle_out", {gpr_we, fpr_we, branch_taken, stall, rx_overflow, wb_addr, branch_target}, 0);
            chk("idle_data", wb_data, 0);
            step();
        end
        // 2: GPR writes
        distinct = 1; RegWrite = 1; rdist = 3; alu_result = 32'h1234; issue();
        chk("t2_gpr_we", gpr_we, 1); chk("t2_addr", wb_addr, 3); chk("t2_data", wb_data, 32'h1234);
        step(); distinct = 1; RegWrite = 1; rdist = 0; alu_result = 32'h1234; issue();
        chk("t2_r0_we", gpr_we, 0);
        step(); distinct = 1; RegWrite = 1; AorF = 1; rdist = 0; MemtoReg = 1; read_data = 32'hDEADBEEF; issue();
        chk("fpr0_we", fpr_we, 1); chk("fpr0_gpr", gpr_we, 0); chk("load_data", wb_data, 32'hDEADBEEF);
        step(); distinct = 1; RegWrite = 1; rdist = 31; MemtoReg = 2; pc1 = 5'h1A; issue();
        chk("link_data", wb_data, 32'h1A);
        step(); distinct = 1; RegWrite = 1; rdist = 4; MemtoReg = 3; register_data = 32'h0BAD_F00D; issue();
        chk("reg_data", wb_data, 32'h0BAD_F00D);
        // 3: branches
        step(); distinct = 1; Branch = 1; alu_result = 1; pc2 = 5'h11; issue();
        chk("t3_cond_tk", branch_taken, 1); chk("t3_cond_tgt", branch_target, 5'h11);
        step(); distinct = 1; Branch = 1; alu_result = 32'h2; pc2 = 5'h11; issue();
        chk("t3_ncond_tk", branch_taken, 0); chk("t3_ncond_tgt", branch_target, 0);
        step(); distinct = 1; Branch = 2; inst_index = 26'h3FF_FFE7; issue();
        chk("t3_jmp_tk", branch_taken, 1); chk("t3_jmp_tgt", branch_target, 5'h07);
        step(); distinct = 1; Branch = 3; register_data = 32'h1F5; issue();
        chk("t3_jr_tgt", branch_target, 5'h15);
        step(); Branch = 2; inst_index = 26'h5; issue();
        chk("t3_bubble_tk", branch_taken, 0);
        // 4: UART read on empty FIFO
        step(); distinct = 1; UARTtoReg = 1; RegWrite = 1; rdist = 7;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("t4_stall", stall, 1);
            step();
        end
        uart_rx_valid = 1; uart_rx_data = 8'hA5; done = 0;
        for (int i = 0; i < 4 && !done; i++) begin
            @(negedge CLK);
            if (!stall) done = 1;
            step();
            uart_rx_valid = 0;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL t4_accept_timeout: got stalled want accepted");
        end
        clr();
        @(negedge CLK);
        chk("t4_we", gpr_we, 1); chk("t4_addr", wb_addr, 7); chk("t4_data", wb_data, 32'hA5);
        // 5: overflow and in-order readout
        step();
        for (int k = 1; k <= 17; k++) begin
            uart_rx_valid = 1; uart_rx_data = 8'(k);
            step();
        end
        clr();
        @(negedge CLK);
        chk("t5_ovf", rx_overflow, 1);
        step(); distinct = 1; UARTtoReg = 1; RegWrite = 1; rdist = 5;
        for (int k = 1; k <= 16; k++) begin
            step();
            @(negedge CLK);
            chk("t5_byte", wb_data, 32'(k));
        end
        chk("t5_drained_stall", stall, 1);
        step(); clr();
        // 6: reset during stall
        distinct = 1; UARTtoReg = 1; RegWrite = 1; rdist = 9;
        @(negedge CLK);
        chk("t6_pre_stall", stall, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_stall", stall, 0);
        chk("t6_rst_ovf", rx_overflow, 0);
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("t6_no_write", gpr_we, 0);
            chk("t6_empty_stall", stall, 1);
            step();
        end
        clr();
        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
